// File: rtl/cla_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_nibble_serial_adder
//
// Purpose: multi-cycle WIDTH-bit adder built around one 4-bit carry-lookahead
// slice. The operands are walked one nibble per clock, least-significant
// nibble first. A registered carry chains the nibbles together.
// A start/ready/done handshake lets a host issue one addition at a time.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst    - synchronous, active-high reset
//   start  - request an addition (accepted only while ready = 1)
//   a, b   - WIDTH-bit operands, latched on the accepting edge
//   cin    - carry into nibble 0, latched on the accepting edge
//   ready  - idle and able to accept start
//   done   - one-cycle pulse: sum/cout/ovf are final
//   sum    - result register
//   cout   - carry out of the most significant nibble
//   ovf    - two's-complement overflow of the latched operands
//
// Also contains carry_lookahead_4bit, the single adder slice.
// -----------------------------------------------------------------------------

module carry_lookahead_4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [4:0] c_s;

    // Generate/propagate terms and the flattened lookahead carry equations
    always_comb begin
        p_s    = x ^ y;
        g_s    = x & y;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
        s      = p_s ^ c_s[3:0];
        cout   = c_s[4];
    end
endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             ready_r;
    logic             done_r;

    logic [WIDTH-1:0] a_sh_s;
    logic [WIDTH-1:0] b_sh_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [3:0]       cla_s;
    logic             cla_cout_s;
    logic [WIDTH-1:0] nib_pos_s;

    // Select the current nibble by shifting it down to bit 0 (idx * 4)
    always_comb begin
        a_sh_s    = a_r >> {idx_r, 2'b00};
        b_sh_s    = b_r >> {idx_r, 2'b00};
        a_nib_s   = a_sh_s[3:0];
        b_nib_s   = b_sh_s[3:0];
        // Place the slice result at its nibble position; sum is cleared on
        // accept, so OR-ing it in keeps nibbles above idx reading zero.
        nib_pos_s = WIDTH'(cla_s) << {idx_r, 2'b00};
    end

    carry_lookahead_4bit u_cla (
        .x    (a_nib_s),
        .y    (b_nib_s),
        .cin  (carry_r),
        .s    (cla_s),
        .cout (cla_cout_s)
    );

    // Control FSM with the operand, carry and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                        idx_r   <= '0;
                        ready_r <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_r   <= sum_r | nib_pos_s;
                    carry_r <= cla_cout_s;
                    if (idx_r == IDX_LAST) begin
                        // Final nibble: its S[3] is the result sign bit
                        cout_r  <= cla_cout_s;
                        ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                   (cla_s[3] != a_r[WIDTH-1]);
                        done_r  <= 1'b1;
                        idx_r   <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                    carry_r <= 1'b0;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign cout  = cout_r;
    assign ovf   = ovf_r;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_nibble_serial_adder
//
// Purpose: self-checking bench for cla_nibble_serial_adder (WIDTH = 16).
// Table of hand-computed vectors issued back-to-back, hand sequences for the
// mid-run, ignored-start and mid-run-reset cases, and a random sweep checked
// against a behavioural a+b+cin model.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cla_nibble_serial_adder;
    localparam int W   = 16;
    localparam int LAT = W / 4 + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    vec_t vecs[8];

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Starts at a falling edge (cycle 0), ends at the falling edge of cycle N+2.
    task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] es,
                          input logic ec, input logic eo);
        int lat;
        chk("ready_before", 32'(ready), 32'd1);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT));
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
        chk("ovf", 32'(ovf), 32'(eo));
        chk("ready_in_done", 32'(ready), 32'd0);
        @(negedge clk);
        chk("ready_after", 32'(ready), 32'd1);
        chk("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   full;
        logic         eo;
        int           dcount;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Table vectors, each started in the cycle ready returns
        for (int i = 0; i < 8; i++) begin
            do_add(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, vecs[i].eo);
        end

        // Partial results during RUN
        a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
        @(negedge clk);  // cycle 1
        start = 1'b0;
        chk("mid_c1_sum", 32'(sum), 32'h0000);
        @(negedge clk);  // cycle 2
        chk("mid_c2_sum", 32'(sum), 32'h0006);
        @(negedge clk);  // cycle 3
        chk("mid_c3_sum", 32'(sum), 32'h0056);
        repeat (2) @(negedge clk);  // cycle 5
        chk("mid_done", 32'(done), 32'd1);
        chk("mid_final", 32'(sum), 32'h5556);
        @(negedge clk);  // cycle 6

        // start while busy is ignored
        dcount = 0;
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) dcount++;
            if (c == 2 || c == 5) begin
                a = 16'hAAAA; b = 16'h5555; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c == 5) begin
                chk("ign_done_c5", 32'(done), 32'd1);
                chk("ign_sum", 32'(sum), 32'h0100);
            end
            if (c == 6) chk("ign_ready_c6", 32'(ready), 32'd1);
        end
        chk("ign_done_count", 32'(dcount), 32'd1);
        chk("ign_sum_hold", 32'(sum), 32'h0100);

        // Reset in cycle 3 of an addition
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);  // cycle 3
        rst = 1'b1;
        start = 1'b1;  // rst wins
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("mrst_ready", 32'(ready), 32'd1);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_sum", 32'(sum), 32'd0);
        chk("mrst_cout", 32'(cout), 32'd0);
        do_add(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Random sweep against a behavioural model
        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            eo = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
            do_add(ra, rb, rc, full[W-1:0], full[W], eo);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
